triangle_sequencer: RTL and testbench

Run-control block for an N-bit up/down triangle-wave counter. It owns the counter's step-enable and clear. It paces steps with a programmable prescaler, runs a requested number of full periods (0→max→0), and optionally dwells at each peak. Completion is reported with a one-cycle `done` pulse. It sits between the register/command interface and the triangle counter that feeds PWM/LED duty logic.

---
 rtl/triangle_seq_pkg.sv | 21 ++
 rtl/triangle_seq_tick_divider.sv | 25 ++
 rtl/triangle_sequencer.sv | 164 ++++++++++++++++
 tb/tb_triangle_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/triangle_seq_pkg.sv
// Shared types and default widths for the triangle-wave run sequencer.
package triangle_seq_pkg;

    localparam int unsigned N_DEF     = 8;
    localparam int unsigned DIV_W_DEF = 16;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DWELL = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/triangle_seq_tick_divider.sv
// tick_divider: one-cycle tick every limit+1 clocks while run is high.
module tick_divider #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] limit,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    assign tick = run && (count == limit);

    // Count 0..limit, wrapping to 0 on the tick; clr forces 0.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/triangle_sequencer.sv
// triangle_sequencer: run control (step pacing, period counting, peak dwell)
// for an external up/down triangle counter.
// Optional peak dwell is compiled in with `define TRIANGLE_SEQ_DWELL_EN.
module triangle_sequencer
    import triangle_seq_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned DIV_W = DIV_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] divider,
    input  logic [CNT_W-1:0] num_cycles,
    input  logic [DIV_W-1:0] dwell,
    input  logic [N-1:0]     wave_in,
    output logic             wave_ena,
    output logic             wave_rst,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycles_done
);

    localparam logic [N-1:0] WAVE_MAX  = '1;
    localparam logic [N-1:0] WAVE_PEAK = WAVE_MAX - N'(1);
    localparam logic [N-1:0] WAVE_ONE  = N'(1);

    state_t           state;
    state_t           state_next;
    dir_t             dir;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] cycles_q;
    logic [CNT_W-1:0] cycles_next;
    logic             presc_tick;
    logic             step;
    logic             top_hit;
    logic             period_end;
    logic             run_done;
    logic             accept;

    assign accept = (state == IDLE) && start && !stop;

    tick_divider #(.DIV_W(DIV_W)) u_presc (
        .clk   (clk),
        .clr   (rst || (state != RUN)),
        .run   (state == RUN),
        .limit (div_q),
        .tick  (presc_tick)
    );

    // A step is suppressed in the stop/reset cycle so the triangle freezes.
    assign step        = presc_tick && !stop && !rst;
    assign top_hit     = step && (dir == UP) && (wave_in == WAVE_MAX);
    assign period_end  = step && (dir == DOWN) && (wave_in == WAVE_ONE);
    assign cycles_next = cycles_q + CNT_W'(1);
    assign run_done    = period_end && (num_q != '0) && (cycles_next == num_q);

`ifdef TRIANGLE_SEQ_DWELL_EN
    logic [DIV_W-1:0] dwell_q;
    logic             dwell_tick;
    logic             peak_hit;

    assign peak_hit = step && (dir == UP) && (wave_in == WAVE_PEAK) && (dwell_q != '0);

    tick_divider #(.DIV_W(DIV_W)) u_dwell (
        .clk   (clk),
        .clr   (rst || (state != DWELL)),
        .run   (state == DWELL),
        .limit (dwell_q - DIV_W'(1)),
        .tick  (dwell_tick)
    );

    // Dwell length is captured with the rest of the run parameters.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q <= '0;
        end else if (accept) begin
            dwell_q <= dwell;
        end
    end
`else
    logic dwell_unused;
    logic peak_unused;
    assign dwell_unused = ^dwell;
    assign peak_unused  = ^WAVE_PEAK;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = CLEAR;
            CLEAR: state_next = stop ? IDLE : RUN;
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (run_done) begin
                    state_next = DONE;
`ifdef TRIANGLE_SEQ_DWELL_EN
                end else if (peak_hit) begin
                    state_next = DWELL;
`endif
                end
            end
`ifdef TRIANGLE_SEQ_DWELL_EN
            DWELL: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (dwell_tick) begin
                    state_next = RUN;
                end
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs; reset forces the quiet values in its own cycle.
    always_comb begin
        wave_rst    = rst || (state == CLEAR);
        wave_ena    = step;
        busy        = !rst && ((state == CLEAR) || (state == RUN) || (state == DWELL));
        done        = !rst && (state == DONE);
        cycles_done = rst ? '0 : cycles_q;
    end

    // Run parameters, direction tracking and completed-period count.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir      <= UP;
            div_q    <= '0;
            num_q    <= '0;
            cycles_q <= '0;
        end else begin
            if (accept) begin
                div_q <= divider;
                num_q <= num_cycles;
            end
            if (state == CLEAR) begin
                dir      <= UP;
                cycles_q <= '0;
            end else if (top_hit) begin
                dir <= DOWN;
            end else if (period_end) begin
                dir      <= UP;
                cycles_q <= cycles_next;
            end
        end
    end

endmodule

// File: tb/tb_triangle_sequencer.sv
// Directed bench for triangle_sequencer with N=4 and a small triangle counter.
module tb_triangle_sequencer;

    localparam int unsigned N     = 4;
    localparam int unsigned DIV_W = 16;
    localparam int unsigned CNT_W = 8;

`ifdef TRIANGLE_SEQ_DWELL_EN
    localparam int DONE1_EXP = 37;
    localparam int HOLD1_EXP = 5;
`else
    localparam int DONE1_EXP = 32;
    localparam int HOLD1_EXP = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic [DIV_W-1:0] divider;
    logic [CNT_W-1:0] num_cycles;
    logic [DIV_W-1:0] dwell;
    logic [N-1:0]     wave;
    logic             wave_ena;
    logic             wave_rst;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycles_done;

    int n_cmp = 0;
    int n_bad = 0;

    // observe() results
    int first_ena, last_ena, n_ena, done_at, n_done, wave_done, busy_done, cyc_done;
    int hold15, misalign, stride;

    triangle_sequencer #(.N(N), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .divider     (divider),
        .num_cycles  (num_cycles),
        .dwell       (dwell),
        .wave_in     (wave),
        .wave_ena    (wave_ena),
        .wave_rst    (wave_rst),
        .busy        (busy),
        .done        (done),
        .cycles_done (cycles_done)
    );

    always #5 clk = ~clk;

    // Bench-side triangle counter 0..15..0 driven by the DUT controls.
    logic wdir;
    always @(posedge clk) begin
        if (wave_rst) begin
            wave <= '0;
            wdir <= 1'b0;
        end else if (wave_ena) begin
            if (!wdir) begin
                if (wave == 4'd15) begin wdir <= 1'b1; wave <= 4'd14; end
                else wave <= wave + 4'd1;
            end else begin
                if (wave == 4'd0) begin wdir <= 1'b0; wave <= 4'd1; end
                else wave <= wave - 4'd1;
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns aligned to cycle t+1.
    task automatic launch(input int div, input int num, input int dw);
        divider    = DIV_W'(div);
        num_cycles = CNT_W'(num);
        dwell      = DIV_W'(dw);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Record activity over cycles t+1..t+ncyc; inject a start (divider=0) at inj_at.
    task automatic observe(input int ncyc, input int inj_at);
        first_ena = -1; last_ena = -1; n_ena = 0; done_at = -1; n_done = 0;
        wave_done = -1; busy_done = -1; cyc_done = -1; hold15 = 0; misalign = 0;
        for (int k = 1; k <= ncyc; k++) begin
            if (k == inj_at) begin
                start   = 1'b1;
                divider = '0;
            end
            if (wave_ena) begin
                if (first_ena < 0) first_ena = k;
                last_ena = k;
                n_ena++;
                if (stride > 0 && ((k - first_ena) % stride) != 0) misalign++;
            end
            if (done) begin
                n_done++;
                if (done_at < 0) begin
                    done_at   = k;
                    wave_done = int'(wave);
                    busy_done = int'(busy);
                    cyc_done  = int'(cycles_done);
                end
            end
            if (wave == 4'd15 && !wave_ena && busy) hold15++;
            tick();
            start = 1'b0;
        end
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        divider = '0; num_cycles = '0; dwell = '0;
        stride = 0;

        // Reset values
        tick();
        check("rst_wave_rst", int'(wave_rst), 1);
        check("rst_ena", int'(wave_ena), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cycles", int'(cycles_done), 0);
        rst = 1'b0;
        tick();
        check("idle_wave_rst", int'(wave_rst), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_wave", int'(wave), 0);

        // One period, divider 0 (dwell port non-zero)
        launch(0, 1, 5);
        check("t1_clear_wave_rst", int'(wave_rst), 1);
        check("t1_clear_busy", int'(busy), 1);
        check("t1_clear_ena", int'(wave_ena), 0);
        observe(45, 0);
        check("t1_first_ena", first_ena, 2);
        check("t1_n_ena", n_ena, 30);
        check("t1_last_ena", last_ena, DONE1_EXP - 1);
        check("t1_done_at", done_at, DONE1_EXP);
        check("t1_n_done", n_done, 1);
        check("t1_wave_at_done", wave_done, 0);
        check("t1_busy_at_done", busy_done, 0);
        check("t1_cycles", cyc_done, 1);
        check("t1_hold15", hold15, HOLD1_EXP);

        // Two periods, divider 3
        stride = 4;
        launch(3, 2, 0);
        observe(260, 0);
        stride = 0;
        check("t2_first_ena", first_ena, 5);
        check("t2_n_ena", n_ena, 60);
        check("t2_misalign", misalign, 0);
        check("t2_last_ena", last_ena, 241);
        check("t2_done_at", done_at, 242);
        check("t2_n_done", n_done, 1);
        check("t2_cycles", cyc_done, 2);

        // Continuous; stop mid-rise at wave 7 after 3 periods
        launch(0, 0, 0);
        k = 1;
        while (!(cycles_done == 8'd3 && wave == 4'd7) && k < 200) begin
            check("t3_no_done_run", int'(done), 0);
            tick();
            k++;
        end
        check("t3_stop_cycle", k, 99);
        stop = 1'b1;
        #1;
        check("t3_stop_ena", int'(wave_ena), 0);
        tick();
        stop = 1'b0;
        check("t3_busy_after", int'(busy), 0);
        check("t3_wave_frozen", int'(wave), 7);
        check("t3_cycles", int'(cycles_done), 3);
        observe(6, 0);
        check("t3_n_done", n_done, 0);
        check("t3_n_ena", n_ena, 0);
        check("t3_wave_still", int'(wave), 7);

        // start together with stop in IDLE is ignored
        start = 1'b1; stop = 1'b1; divider = '0; num_cycles = 8'd1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("t4_busy", int'(busy), 0);
        check("t4_wave_rst", int'(wave_rst), 0);
        tick();
        check("t4_busy2", int'(busy), 0);

        // start during RUN ignored: latched divider 3 keeps pacing
        launch(3, 1, 0);
        observe(130, 20);
        check("t5_first_ena", first_ena, 5);
        check("t5_n_ena", n_ena, 30);
        check("t5_done_at", done_at, 122);
        check("t5_n_done", n_done, 1);
        check("t5_cycles", cyc_done, 1);

        // Reset mid-RUN after one completed period
        launch(0, 0, 0);
        observe(40, 0);
        check("t6_cycles_pre", int'(cycles_done), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_wave_rst", int'(wave_rst), 1);
        check("t6_rst_ena", int'(wave_ena), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_cycles", int'(cycles_done), 0);
        tick();
        rst = 1'b0;
        #1;
        check("t6_post_busy", int'(busy), 0);
        check("t6_post_wave_rst", int'(wave_rst), 0);
        check("t6_post_ena", int'(wave_ena), 0);
        check("t6_post_wave", int'(wave), 0);
        check("t6_post_cycles", int'(cycles_done), 0);
        tick();
        launch(0, 1, 5);
        observe(45, 0);
        check("t6_rerun_first", first_ena, 2);
        check("t6_rerun_n_ena", n_ena, 30);
        check("t6_rerun_done_at", done_at, DONE1_EXP);
        check("t6_rerun_cycles", cyc_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
